// File: rtl/shared_bus_arbiter_if.sv
// Bundles the per-master request/response signals and the decoder-facing bus.
// The master modport is the arbiter's view; slave is the view of masters, decoder and slaves.
interface shared_bus_arbiter_if #(
  parameter int N_MASTERS = 4,
  parameter int AW        = 8,
  parameter int DW        = 8
);
  logic [N_MASTERS-1:0]    m_req;
  logic [N_MASTERS-1:0]    m_we;
  logic [N_MASTERS*AW-1:0] m_addr;
  logic [N_MASTERS*DW-1:0] m_wdata;
  logic [N_MASTERS-1:0]    m_done;
  logic [N_MASTERS-1:0]    m_err;
  logic [DW-1:0]           m_rdata;
  logic [N_MASTERS-1:0]    grant;
  logic [AW-1:0]           bus_addr;
  logic                    bus_read;
  logic                    bus_write;
  logic [DW-1:0]           bus_wdata;
  logic [DW-1:0]           bus_rdata;
  logic                    bus_ack;

  modport master (
    input  m_req, m_we, m_addr, m_wdata, bus_rdata, bus_ack,
    output m_done, m_err, m_rdata, grant, bus_addr, bus_read, bus_write, bus_wdata
  );

  modport slave (
    output m_req, m_we, m_addr, m_wdata, bus_rdata, bus_ack,
    input  m_done, m_err, m_rdata, grant, bus_addr, bus_read, bus_write, bus_wdata
  );
endinterface

// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter in front of the address decoder: grants one master at a time,
// drives the shared bus until the slave acks or the access times out, then reports back.
module shared_bus_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  shared_bus_arbiter_if.master bus
);

  localparam int PW = $clog2(N_MASTERS);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        gidx_q, gidx_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic                 we_q, we_d;
  logic                 err_q, err_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 sel_found;
  logic [PW-1:0]        sel_idx;
  logic [PW-1:0]        cand;

  // First requester at or after the rotating pointer, wrapping modulo N_MASTERS.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      cand = PW'((int'(ptr_q) + i) % N_MASTERS);
      if (!sel_found && bus.m_req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          gidx_d          = sel_idx;
          grant_d         = '0;
          grant_d[sel_idx] = 1'b1;
          addr_d          = bus.m_addr[sel_idx*AW +: AW];
          wdata_d         = bus.m_wdata[sel_idx*DW +: DW];
          we_d            = bus.m_we[sel_idx];
          cnt_d           = '0;
          err_d           = 1'b0;
          state_d         = ACCESS;
        end
      end

      // An ack in the final allowed cycle still completes normally.
      ACCESS: begin
        if (bus.bus_ack) begin
          if (!we_q) begin
            rdata_d = bus.bus_rdata;
          end
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RESP: begin
        ptr_d   = (gidx_q == PW'(N_MASTERS - 1)) ? '0 : gidx_q + PW'(1);
        cnt_d   = '0;
        err_d   = 1'b0;
        grant_d = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bus-side outputs are forced to zero outside ACCESS so the decoder sees a quiet bus.
  assign bus.grant     = grant_q;
  assign bus.bus_addr  = (state_q == ACCESS) ? addr_q  : '0;
  assign bus.bus_wdata = (state_q == ACCESS) ? wdata_q : '0;
  assign bus.bus_read  = (state_q == ACCESS) && !we_q;
  assign bus.bus_write = (state_q == ACCESS) &&  we_q;
  assign bus.m_done    = (state_q == RESP) ? grant_q : '0;
  assign bus.m_err     = (state_q == RESP && err_q) ? grant_q : '0;
  assign bus.m_rdata   = rdata_q;

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed testbench for shared_bus_arbiter: read, contention, write with wait,
// timeout, ack on the last allowed cycle and reset in the middle of an access.
module tb_shared_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  shared_bus_arbiter_if #(.N_MASTERS(N), .AW(AW), .DW(DW)) bus_if ();

  shared_bus_arbiter #(.N_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bus_if.m_addr[idx*AW +: AW]  = addr;
    bus_if.m_wdata[idx*DW +: DW] = wdata;
  endtask

  // Watchdog so a stuck DUT still ends the run with a report.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] exp_g;

    bus_if.m_req     = '0;
    bus_if.m_we      = '0;
    bus_if.m_addr    = '0;
    bus_if.m_wdata   = '0;
    bus_if.bus_rdata = '0;
    bus_if.bus_ack   = 1'b0;

    // Reset state
    rst = 1'b1;
    waitCycle();
    waitCycle();
    rst = 1'b0;
    checkOutput("rst_grant", 32'(bus_if.grant), 32'h0);
    checkOutput("rst_read", 32'(bus_if.bus_read), 32'h0);
    checkOutput("rst_write", 32'(bus_if.bus_write), 32'h0);
    checkOutput("rst_addr", 32'(bus_if.bus_addr), 32'h0);
    checkOutput("rst_done", 32'(bus_if.m_done), 32'h0);
    checkOutput("rst_rdata", 32'(bus_if.m_rdata), 32'h0);

    // 1: single read, ack in first ACCESS cycle
    applyStimulus(0, 8'h05, 8'h00);
    bus_if.m_we  = 4'b0000;
    bus_if.m_req = 4'b0001;
    waitCycle();
    checkOutput("t1_read", 32'(bus_if.bus_read), 32'h1);
    checkOutput("t1_write", 32'(bus_if.bus_write), 32'h0);
    checkOutput("t1_addr", 32'(bus_if.bus_addr), 32'h05);
    checkOutput("t1_grant", 32'(bus_if.grant), 32'h1);
    checkOutput("t1_done_early", 32'(bus_if.m_done), 32'h0);
    bus_if.bus_rdata = 8'hA5;
    bus_if.bus_ack   = 1'b1;
    waitCycle();
    bus_if.bus_ack = 1'b0;
    checkOutput("t1_done", 32'(bus_if.m_done), 32'h1);
    checkOutput("t1_err", 32'(bus_if.m_err), 32'h0);
    checkOutput("t1_rdata", 32'(bus_if.m_rdata), 32'hA5);
    checkOutput("t1_read_resp", 32'(bus_if.bus_read), 32'h0);
    checkOutput("t1_grant_resp", 32'(bus_if.grant), 32'h1);
    bus_if.m_req = 4'b0000;
    waitCycle();
    checkOutput("t1_idle_grant", 32'(bus_if.grant), 32'h0);
    checkOutput("t1_idle_read", 32'(bus_if.bus_read), 32'h0);

    // 2: contention from a fresh pointer, ack always high
    rst = 1'b1;
    waitCycle();
    rst = 1'b0;
    bus_if.bus_rdata = 8'h77;
    bus_if.bus_ack   = 1'b1;
    bus_if.m_we      = 4'b0000;
    bus_if.m_req     = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_g = 32'h1 << (t % 4);
      waitCycle();
      checkOutput("t2_grant", 32'(bus_if.grant), exp_g);
      checkOutput("t2_read", 32'(bus_if.bus_read), 32'h1);
      waitCycle();
      checkOutput("t2_done", 32'(bus_if.m_done), exp_g);
      if (t == 4) bus_if.m_req = 4'b0000;
      waitCycle();
      checkOutput("t2_idle_grant", 32'(bus_if.grant), 32'h0);
    end
    bus_if.bus_ack = 1'b0;

    // 3: master 2 write with three wait cycles; payload change after grant ignored
    applyStimulus(2, 8'h12, 8'h3C);
    bus_if.bus_rdata = 8'hEE;
    bus_if.m_we      = 4'b0100;
    bus_if.m_req     = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      waitCycle();
      checkOutput("t3_write", 32'(bus_if.bus_write), 32'h1);
      checkOutput("t3_read", 32'(bus_if.bus_read), 32'h0);
      checkOutput("t3_addr", 32'(bus_if.bus_addr), 32'h12);
      checkOutput("t3_wdata", 32'(bus_if.bus_wdata), 32'h3C);
      checkOutput("t3_grant", 32'(bus_if.grant), 32'h4);
      if (c == 0) applyStimulus(2, 8'hFF, 8'h00);
      if (c == 3) bus_if.bus_ack = 1'b1;
    end
    waitCycle();
    bus_if.bus_ack = 1'b0;
    checkOutput("t3_done", 32'(bus_if.m_done), 32'h4);
    checkOutput("t3_err", 32'(bus_if.m_err), 32'h0);
    checkOutput("t3_rdata_kept", 32'(bus_if.m_rdata), 32'h77);
    checkOutput("t3_write_resp", 32'(bus_if.bus_write), 32'h0);
    bus_if.m_req = 4'b0000;
    bus_if.m_we  = 4'b0000;
    waitCycle();

    // 4: master 1 read to unmapped address times out; master 2 waiting next
    applyStimulus(1, 8'h40, 8'h00);
    applyStimulus(2, 8'h22, 8'h00);
    bus_if.m_req = 4'b0110;
    for (int c = 0; c < 15; c++) begin
      waitCycle();
      checkOutput("t4_read", 32'(bus_if.bus_read), 32'h1);
      checkOutput("t4_grant", 32'(bus_if.grant), 32'h2);
      checkOutput("t4_addr", 32'(bus_if.bus_addr), 32'h40);
    end
    waitCycle();
    checkOutput("t4_done", 32'(bus_if.m_done), 32'h2);
    checkOutput("t4_err", 32'(bus_if.m_err), 32'h2);
    checkOutput("t4_read_resp", 32'(bus_if.bus_read), 32'h0);
    bus_if.m_req = 4'b0100;
    waitCycle();
    checkOutput("t4_idle_grant", 32'(bus_if.grant), 32'h0);
    waitCycle();
    checkOutput("t4_next_grant", 32'(bus_if.grant), 32'h4);
    checkOutput("t4_next_addr", 32'(bus_if.bus_addr), 32'h22);
    bus_if.bus_rdata = 8'hC3;
    bus_if.bus_ack   = 1'b1;
    waitCycle();
    bus_if.bus_ack = 1'b0;
    checkOutput("t4_next_done", 32'(bus_if.m_done), 32'h4);
    checkOutput("t4_next_rdata", 32'(bus_if.m_rdata), 32'hC3);
    bus_if.m_req = 4'b0000;
    waitCycle();

    // 5: ack arrives on the 15th ACCESS cycle, the same cycle the timeout would fire
    applyStimulus(0, 8'h50, 8'h00);
    bus_if.bus_rdata = 8'h5A;
    bus_if.m_req     = 4'b0001;
    for (int c = 0; c < 15; c++) begin
      waitCycle();
      checkOutput("t5_read", 32'(bus_if.bus_read), 32'h1);
      checkOutput("t5_grant", 32'(bus_if.grant), 32'h1);
      if (c == 14) bus_if.bus_ack = 1'b1;
    end
    waitCycle();
    bus_if.bus_ack = 1'b0;
    checkOutput("t5_done", 32'(bus_if.m_done), 32'h1);
    checkOutput("t5_err", 32'(bus_if.m_err), 32'h0);
    checkOutput("t5_rdata", 32'(bus_if.m_rdata), 32'h5A);
    bus_if.m_req = 4'b0000;
    waitCycle();

    // 6: reset during ACCESS aborts silently and restarts arbitration at master 0
    applyStimulus(2, 8'h33, 8'h00);
    applyStimulus(0, 8'h01, 8'h00);
    bus_if.m_req = 4'b0100;
    waitCycle();
    checkOutput("t6_grant_before", 32'(bus_if.grant), 32'h4);
    rst          = 1'b1;
    bus_if.m_req = 4'b0101;
    waitCycle();
    rst = 1'b0;
    checkOutput("t6_grant", 32'(bus_if.grant), 32'h0);
    checkOutput("t6_read", 32'(bus_if.bus_read), 32'h0);
    checkOutput("t6_addr", 32'(bus_if.bus_addr), 32'h0);
    checkOutput("t6_done", 32'(bus_if.m_done), 32'h0);
    checkOutput("t6_err", 32'(bus_if.m_err), 32'h0);
    checkOutput("t6_rdata", 32'(bus_if.m_rdata), 32'h0);
    waitCycle();
    checkOutput("t6_restart_grant", 32'(bus_if.grant), 32'h1);
    checkOutput("t6_restart_addr", 32'(bus_if.bus_addr), 32'h01);
    bus_if.bus_ack = 1'b1;
    waitCycle();
    bus_if.bus_ack = 1'b0;
    checkOutput("t6_restart_done", 32'(bus_if.m_done), 32'h1);
    bus_if.m_req = 4'b0000;
    waitCycle();
    checkOutput("t6_final_grant", 32'(bus_if.grant), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
